// File: rtl/fir_frame_ctrl.sv
// Frame sequencer in front of a FIR filter: forwards framed samples, appends the
// zero tail, counts filter outputs and tags m_last. Optional filter clear via FIR_FRAME_CLEAR_EN.
module fir_frame_ctrl #(
  parameter int unsigned INPUT_WIDTH   = 16,
  parameter int unsigned OUTPUT_WIDTH  = 26,
  parameter int unsigned NUM_TAPS      = 37,
  parameter int unsigned MAX_FRAME     = 1024,
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic                    s_last,
  output logic                    fir_rst,
  output logic                    fir_valid_in,
  output logic [INPUT_WIDTH-1:0]  fir_din,
  input  logic                    fir_valid_out,
  input  logic [OUTPUT_WIDTH-1:0] fir_dout,
  output logic                    m_valid,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_overflow,
  output logic                    err_timeout
);

  localparam int unsigned CW = $clog2(MAX_FRAME + NUM_TAPS) + 1;
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] TAIL       = CW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(NUM_TAPS - 2);
  localparam logic [CW-1:0] FRAME_MAX  = CW'(MAX_FRAME);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(DRAIN_TIMEOUT - 1);

  if (NUM_TAPS < 2 || CLEAR_CYCLES < 1 || DRAIN_TIMEOUT < 1 || MAX_FRAME < 1) begin : g_bad_param
    $error("fir_frame_ctrl: invalid parameter set");
  end

`ifdef FIR_FRAME_CLEAR_EN
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, FLUSH = 3'd2, DRAIN = 3'd3, CLEAR = 3'd4} state_t;
  localparam int unsigned KW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [KW-1:0] CLR_LAST = KW'(CLEAR_CYCLES - 1);
  logic [KW-1:0] clr_cnt, clr_cnt_nxt;
  logic          fir_rst_nxt;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, FLUSH = 3'd2, DRAIN = 3'd3} state_t;
`endif

  state_t                 state, state_nxt;
  logic [CW-1:0]          in_cnt, in_cnt_nxt;
  logic [CW-1:0]          flush_cnt, flush_cnt_nxt;
  logic [CW-1:0]          out_cnt, out_cnt_nxt;
  logic [TW-1:0]          idle_cnt, idle_cnt_nxt;
  logic                   s_ready_nxt, busy_nxt, fir_valid_in_nxt;
  logic [INPUT_WIDTH-1:0] fir_din_nxt;
  logic                   err_overflow_nxt, err_timeout_nxt;

  logic          accept_c, active_c, drain_done_c, frame_end_c, trunc_c;
  logic [CW-1:0] beat_cnt_c, tgt_c;

  // Output path is combinational so forwarded filter samples add no latency
  assign active_c     = (state == RUN) || (state == FLUSH) || (state == DRAIN);
  assign m_valid      = fir_valid_out & active_c;
  assign m_data       = fir_dout;
  assign tgt_c        = in_cnt + TAIL;
  assign m_last       = m_valid & ((out_cnt + CW'(1)) == tgt_c);
  assign drain_done_c = m_last | (out_cnt >= tgt_c);

  assign accept_c    = s_valid & s_ready;
  assign beat_cnt_c  = (state == IDLE) ? CW'(1) : in_cnt + CW'(1);
  assign trunc_c     = ~s_last & (beat_cnt_c == FRAME_MAX);
  assign frame_end_c = s_last | (beat_cnt_c == FRAME_MAX);

  always_comb begin
    state_nxt        = state;
    in_cnt_nxt       = in_cnt;
    flush_cnt_nxt    = flush_cnt;
    out_cnt_nxt      = m_valid ? out_cnt + CW'(1) : out_cnt;
    idle_cnt_nxt     = idle_cnt;
    fir_valid_in_nxt = 1'b0;
    fir_din_nxt      = '0;
    err_overflow_nxt = err_overflow;
    err_timeout_nxt  = err_timeout;
`ifdef FIR_FRAME_CLEAR_EN
    clr_cnt_nxt      = clr_cnt;
    fir_rst_nxt      = 1'b0;
`endif

    case (state)
      IDLE, RUN: begin
        if (accept_c) begin
          in_cnt_nxt       = beat_cnt_c;
          fir_valid_in_nxt = 1'b1;
          fir_din_nxt      = s_data;
          flush_cnt_nxt    = '0;
          if (state == IDLE) begin
            out_cnt_nxt = '0;
            state_nxt   = RUN;
          end
          if (frame_end_c) begin
            state_nxt = FLUSH;
          end
          if (trunc_c) begin
            err_overflow_nxt = 1'b1;
          end
        end
      end

      FLUSH: begin
        fir_valid_in_nxt = 1'b1;
        flush_cnt_nxt    = flush_cnt + CW'(1);
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt    = DRAIN;
          idle_cnt_nxt = '0;
        end
      end

      DRAIN: begin
        if (drain_done_c || (!m_valid && idle_cnt == IDLE_LAST)) begin
          if (!drain_done_c) begin
            err_timeout_nxt = 1'b1;
          end
`ifdef FIR_FRAME_CLEAR_EN
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          fir_rst_nxt = 1'b1;
`else
          state_nxt   = IDLE;
`endif
        end else if (m_valid) begin
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + TW'(1);
        end
      end

`ifdef FIR_FRAME_CLEAR_EN
      // Hold the filter in reset so each frame starts from an empty pipeline
      CLEAR: begin
        fir_rst_nxt = 1'b1;
        clr_cnt_nxt = clr_cnt + KW'(1);
        if (clr_cnt == CLR_LAST) begin
          fir_rst_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase

    s_ready_nxt = (state_nxt == IDLE) || (state_nxt == RUN);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_cnt       <= '0;
      flush_cnt    <= '0;
      out_cnt      <= '0;
      idle_cnt     <= '0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      fir_valid_in <= 1'b0;
      fir_din      <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      in_cnt       <= in_cnt_nxt;
      flush_cnt    <= flush_cnt_nxt;
      out_cnt      <= out_cnt_nxt;
      idle_cnt     <= idle_cnt_nxt;
      s_ready      <= s_ready_nxt;
      busy         <= busy_nxt;
      fir_valid_in <= fir_valid_in_nxt;
      fir_din      <= fir_din_nxt;
      err_overflow <= err_overflow_nxt;
      err_timeout  <= err_timeout_nxt;
    end
  end

`ifdef FIR_FRAME_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      fir_rst <= 1'b0;
    end else begin
      clr_cnt <= clr_cnt_nxt;
      fir_rst <= fir_rst_nxt;
    end
  end
`else
  assign fir_rst = 1'b0;
`endif

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Bench for fir_frame_ctrl: behavioural pipelined 37-tap FIR stub, frame driver with
// a convolution scoreboard, table-driven frames plus overflow/timeout/reset sequences.
module tb_fir_frame_ctrl;

  localparam int IW   = 16;
  localparam int OW   = 26;
  localparam int NT   = 37;
  localparam int MAXF = 40;
  localparam int CLRC = 4;
  localparam int DTO  = 256;
  localparam int LAT  = 3;
`ifdef FIR_FRAME_CLEAR_EN
  localparam int CLR_EXP = CLRC;
`else
  localparam int CLR_EXP = 0;
`endif

  logic          clk, rst;
  logic          s_valid, s_ready, s_last;
  logic [IW-1:0] s_data;
  logic          fir_rst, fir_valid_in, fir_valid_out;
  logic [IW-1:0] fir_din;
  logic [OW-1:0] fir_dout;
  logic          m_valid, m_last, busy, err_overflow, err_timeout;
  logic [OW-1:0] m_data;

  fir_frame_ctrl #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUM_TAPS(NT), .MAX_FRAME(MAXF),
    .CLEAR_CYCLES(CLRC), .DRAIN_TIMEOUT(DTO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fir_rst(fir_rst), .fir_valid_in(fir_valid_in), .fir_din(fir_din),
    .fir_valid_out(fir_valid_out), .fir_dout(fir_dout), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int coef(int k);
    int d;
    d = (k < NT - 1 - k) ? k : NT - 1 - k;
    return (k == NT / 2) ? 127 : 8 + d;
  endfunction

  // Filter stub: shift register, full-precision MAC, LAT-stage output pipeline
  int            sr [NT-1];
  int            acc;
  logic          pv [LAT];
  logic [OW-1:0] pd [LAT];
  logic          stub_dead;

  always @* begin
    acc = coef(0) * int'($signed(fir_din));
    for (int k = 1; k < NT; k++) acc += coef(k) * sr[k-1];
  end

  always @(posedge clk or posedge rst) begin
    if (rst || fir_rst) begin
      for (int k = 0; k < NT - 1; k++) sr[k] <= 0;
      for (int k = 0; k < LAT; k++) begin pv[k] <= 1'b0; pd[k] <= '0; end
    end else begin
      pv[0] <= fir_valid_in;
      pd[0] <= OW'(acc);
      for (int k = 1; k < LAT; k++) begin pv[k] <= pv[k-1]; pd[k] <= pd[k-1]; end
      if (fir_valid_in) begin
        sr[0] <= int'($signed(fir_din));
        for (int k = 1; k < NT - 1; k++) sr[k] <= sr[k-1];
      end
    end
  end

  assign fir_valid_out = pv[LAT-1] & ~stub_dead;
  assign fir_dout      = pd[LAT-1];

  typedef struct { logic [OW-1:0] data; logic last; } exp_t;
  exp_t sb[$];
  int   fx[$];
  logic exp_ovf;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] yval(int n);
    int a = 0;
    for (int k = 0; k < NT; k++)
      if (n - k >= 0 && n - k < fx.size()) a += coef(k) * fx[n-k];
    return OW'(a);
  endfunction

  // Scoreboard model: one head output per accepted beat, NT-1 tail outputs at frame end
  task automatic model_accept(logic [IW-1:0] x, logic last);
    int n;
    fx.push_back(int'($signed(x)));
    sb.push_back('{yval(fx.size() - 1), 1'b0});
    if (last || fx.size() == MAXF) begin
      if (!last) exp_ovf = 1'b1;
      n = fx.size();
      for (int t = n; t <= n + NT - 2; t++) sb.push_back('{yval(t), t == n + NT - 2});
      fx.delete();
    end
  endtask

  // Monitor counters
  int out_cnt, last_cnt, vin_cnt, run, max_run, rst_cnt, busy_cyc;

  task automatic clr_counters();
    out_cnt = 0; last_cnt = 0; vin_cnt = 0; run = 0; max_run = 0; rst_cnt = 0; busy_cyc = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fir_valid_in) begin
        vin_cnt++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (fir_rst) rst_cnt++;
      if (busy) busy_cyc++;
      if (m_valid) begin
        out_cnt++;
        if (m_last) last_cnt++;
        if (sb.size() == 0) check("m_valid_unexpected", m_valid, 1'b0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
      end
    end
  end

  task automatic send_beat(logic [IW-1:0] x, logic last);
    int w = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = x; s_last = last;
    while (!s_ready && w < 1000) begin @(negedge clk); w++; end
    if (!s_ready) begin
      check("s_ready_wait", s_ready, 1'b1);
    end else begin
      @(posedge clk);
      model_accept(x, last);
    end
    #1 s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int w = 0;
    do begin @(negedge clk); w++; end while ((busy || sb.size() != 0) && w < bound);
    check("frame_done", {busy, sb.size() != 0}, 2'b00);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fir_valid_in"}, fir_valid_in, 0);
    check({tag, "_fir_din"}, fir_din, 0);
    check({tag, "_fir_rst"}, fir_rst, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_err_overflow"}, err_overflow, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  typedef struct {
    int            len;
    logic          gap;
    logic          rnd;
    logic [IW-1:0] base;
    int            exp_out;
    int            exp_run;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,    1'b0, 1'b0, 16'h8000, 37, 37};
    tbl[1] = '{37,   1'b0, 1'b0, 16'h8000, 73, 73};
    tbl[2] = '{10,   1'b1, 1'b0, 16'h0123, 46, 0};
    tbl[3] = '{5,    1'b0, 1'b1, 16'h0000, 41, 41};
    tbl[4] = '{20,   1'b0, 1'b1, 16'h0000, 56, 56};
    tbl[5] = '{MAXF, 1'b0, 1'b1, 16'h0000, MAXF + NT - 1, MAXF + NT - 1};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; stub_dead = 1'b0; exp_ovf = 1'b0;
    clr_counters();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_s_ready", s_ready, 1'b1);
    check("post_reset_busy", busy, 1'b0);

    for (int v = 0; v < 6; v++) begin
      clr_counters();
      for (int i = 0; i < tbl[v].len; i++) begin
        logic [IW-1:0] x;
        x = tbl[v].rnd ? IW'($urandom) : (tbl[v].gap ? tbl[v].base + IW'(i) : tbl[v].base);
        send_beat(x, i == tbl[v].len - 1);
        if (tbl[v].gap) @(negedge clk);
      end
      wait_idle(2000);
      check($sformatf("vec%0d_outputs", v), out_cnt, tbl[v].exp_out);
      check($sformatf("vec%0d_last_cnt", v), last_cnt, 1);
      check($sformatf("vec%0d_fir_valid_in", v), vin_cnt, tbl[v].len + NT - 1);
      if (tbl[v].exp_run != 0) check($sformatf("vec%0d_vin_run", v), max_run, tbl[v].exp_run);
      check($sformatf("vec%0d_fir_rst_cycles", v), rst_cnt, CLR_EXP);
      check($sformatf("vec%0d_err_overflow", v), err_overflow, exp_ovf);
      check($sformatf("vec%0d_err_timeout", v), err_timeout, 1'b0);
    end

    // Back-to-back 5-beat frames
    clr_counters();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 5; i++) send_beat(IW'($urandom), i == 4);
    wait_idle(2000);
    check("b2b_outputs", out_cnt, 82);
    check("b2b_last_cnt", last_cnt, 2);
    check("b2b_fir_rst_cycles", rst_cnt, 2 * CLR_EXP);
    check("b2b_fir_valid_in", vin_cnt, 82);

    // Truncation at MAXF; the surplus 3 beats form the next frame
    clr_counters();
    for (int i = 0; i < MAXF + 3; i++) send_beat(IW'($urandom), i == MAXF + 2);
    wait_idle(3000);
    check("ovf_outputs", out_cnt, (MAXF + NT - 1) + (3 + NT - 1));
    check("ovf_last_cnt", last_cnt, 2);
    check("ovf_err_overflow", err_overflow, 1'b1);
    check("ovf_model_flag", err_overflow, exp_ovf);
    check("ovf_err_timeout", err_timeout, 1'b0);

    // Dead filter: drain must abort after DTO silent cycles
    stub_dead = 1'b1;
    clr_counters();
    send_beat(16'h8000, 1'b1);
    begin
      int w = 0;
      while (busy && w < 800) begin @(negedge clk); w++; end
    end
    check("tmo_busy", busy, 1'b0);
    check("tmo_err_timeout", err_timeout, 1'b1);
    check("tmo_busy_cycles", busy_cyc, (NT - 1) + DTO + CLR_EXP);
    check("tmo_outputs", out_cnt, 0);
    sb.delete();
    stub_dead = 1'b0;

    // Reset in the middle of a frame
    clr_counters();
    for (int i = 0; i < 3; i++) send_beat(IW'($urandom), 1'b0);
    @(negedge clk);
    check("midrun_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    sb.delete(); fx.delete(); exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clr_counters();
    send_beat(16'h8000, 1'b1);
    wait_idle(2000);
    check("recover_outputs", out_cnt, NT);
    check("recover_last_cnt", last_cnt, 1);
    check("recover_err_overflow", err_overflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
